// File: rtl/cpu_decode_if.sv
// 68030 bus-side signal bundle between the CPU card pins and the address decoder.
// master drives the CPU bus inputs; slave is the decoder.
interface cpu_decode_if;
  logic        nAS;
  logic        RnW;
  logic [2:0]  FC;
  logic [15:0] ADDR;
  logic [1:0]  nDSACK;
  logic        nRAMSEL;
  logic        nROMSEL;
  logic [3:0]  nIOSEL;
  logic [1:0]  ROM_DSACK;
  logic        AVEC;
  logic        BERR;
  logic        OVERLAY;

  modport master (
    output nAS, RnW, FC, ADDR, nDSACK,
    input  nRAMSEL, nROMSEL, nIOSEL, ROM_DSACK, AVEC, BERR, OVERLAY
  );

  modport slave (
    input  nAS, RnW, FC, ADDR, nDSACK,
    output nRAMSEL, nROMSEL, nIOSEL, ROM_DSACK, AVEC, BERR, OVERLAY
  );
endinterface

// File: rtl/cpu_decode.sv
// Address decoder and bus-cycle supervisor: chip selects, boot ROM overlay,
// ROM wait states, autovector and bus-error generation for the 68030 card.
module cpu_decode #(
  parameter int unsigned ROM_WS       = 6,
  parameter int unsigned BERR_TIMEOUT = 500
) (
  input logic         CLK,
  input logic         nRST,
  cpu_decode_if.slave bus
);

  typedef enum logic [2:0] {
    ClsUnmapped, ClsDram, ClsRomLow, ClsRomNative, ClsIo, ClsIack
  } cls_e;

  typedef enum logic [2:0] {
    StIdle, StRomWait, StRomAck, StDone, StFault
  } state_e;

  cls_e       cls_dec, cls_q;
  state_e     state_q, state_d;
  logic       as1_q, as_q;
  logic [1:0] ds1_q, ds_q;
  logic       dsack_seen;
  logic [3:0] ws_q, ws_d;
  logic [9:0] wd_q, wd_d;
  logic       wd_clr;
  logic [1:0] rom_dsack_q, rom_dsack_d;
  logic       avec_q, avec_d, berr_q, berr_d;
  logic       overlay_q, overlay_d, rom_native_q, rom_native_d;
  logic       sel_en;
  logic [3:0] io_sel_n;

  // Decode straight from pins; CPU space never produces a chip select.
  always_comb begin
    cls_dec = ClsUnmapped;
    if (bus.FC == 3'b111) begin
      if (bus.ADDR[3:0] == 4'hF) cls_dec = ClsIack;
    end else if (bus.ADDR[15:12] == 4'h0) begin
      cls_dec = (overlay_q && bus.RnW) ? ClsRomLow : ClsDram;
    end else if (bus.ADDR[15:4] == 12'hFFF) begin
      cls_dec = ClsRomNative;
    end else if (bus.ADDR[15:4] == 12'hFFE) begin
      cls_dec = ClsIo;
    end
  end

  assign sel_en = nRST && !bus.nAS;

  always_comb begin
    io_sel_n = 4'hF;
    if (sel_en && cls_dec == ClsIo) io_sel_n[bus.ADDR[3:2]] = 1'b0;
  end

  assign bus.nRAMSEL   = ~(sel_en && cls_dec == ClsDram);
  assign bus.nROMSEL   = ~(sel_en && (cls_dec == ClsRomLow || cls_dec == ClsRomNative));
  assign bus.nIOSEL    = io_sel_n;
  assign bus.ROM_DSACK = rom_dsack_q;
  assign bus.AVEC      = avec_q;
  assign bus.BERR      = berr_q;
  assign bus.OVERLAY   = overlay_q;

  assign dsack_seen = |ds_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      as1_q <= 1'b0;
      as_q  <= 1'b0;
      ds1_q <= 2'b00;
      ds_q  <= 2'b00;
      cls_q <= ClsUnmapped;
    end else begin
      as1_q <= ~bus.nAS;
      as_q  <= as1_q;
      ds1_q <= ~bus.nDSACK;
      ds_q  <= ds1_q;
      if (as1_q && !as_q) cls_q <= cls_dec;
    end
  end

  always_comb begin
    state_d      = state_q;
    ws_d         = ws_q;
    rom_dsack_d  = rom_dsack_q;
    avec_d       = avec_q;
    berr_d       = berr_q;
    overlay_d    = overlay_q;
    rom_native_d = rom_native_q;
    wd_clr       = !as_q || dsack_seen || avec_q || (rom_dsack_q != 2'b00) || berr_q;
    wd_d         = wd_clr ? 10'd0 : wd_q + 10'd1;

    unique case (state_q)
      StIdle: begin
        if (as_q) begin
          unique case (cls_q)
            ClsRomLow, ClsRomNative: begin
              ws_d    = 4'(ROM_WS - 1);
              state_d = StRomWait;
              if (cls_q == ClsRomNative) rom_native_d = 1'b1;
            end
            ClsIack: begin
              avec_d  = 1'b1;
              state_d = StDone;
            end
            ClsUnmapped: begin
              berr_d  = 1'b1;
              state_d = StFault;
            end
            default: state_d = StDone;
          endcase
        end
      end
      StRomWait: begin
        ws_d = ws_q - 4'd1;
        // <= 1 so that ROM_WS=1 (loaded as 0) still leaves after one cycle.
        if (ws_q <= 4'd1) begin
          rom_dsack_d = 2'b10;
          state_d     = StRomAck;
        end
      end
      StRomAck, StDone, StFault: begin
        if (!as_q) begin
          rom_dsack_d = 2'b00;
          avec_d      = 1'b0;
          berr_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Termination sensed on the same edge clears the counter and wins.
    if (state_q != StIdle && !wd_clr && wd_q == 10'(BERR_TIMEOUT - 1)) begin
      berr_d  = 1'b1;
      state_d = StFault;
    end

    if (rom_native_q && !as_q) begin
      rom_native_d = 1'b0;
      overlay_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      ws_q         <= 4'd0;
      wd_q         <= 10'd0;
      rom_dsack_q  <= 2'b00;
      avec_q       <= 1'b0;
      berr_q       <= 1'b0;
      overlay_q    <= 1'b1;
      rom_native_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ws_q         <= ws_d;
      wd_q         <= wd_d;
      rom_dsack_q  <= rom_dsack_d;
      avec_q       <= avec_d;
      berr_q       <= berr_d;
      overlay_q    <= overlay_d;
      rom_native_q <= rom_native_d;
    end
  end

endmodule
